// File: rtl/nv_clk_gate_pkg.sv
// Shared types and constants for the multi-channel power clock gate.
// Holds the per-channel state encoding, the mode field values and the request decode.
package nv_clk_gate_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } ch_state_e;

  localparam logic [1:0] MODE_AUTO     = 2'b00;
  localparam logic [1:0] MODE_FON      = 2'b01;
  localparam logic [1:0] MODE_FOFF     = 2'b10;
  localparam logic [1:0] MODE_AUTO_ALT = 2'b11;

  localparam int GATE_CNT_W = 16;

  // Encoding 11 is reserved and behaves exactly like auto.
  function automatic logic mode_req(input logic [1:0] mode, input logic busy);
    return (mode == MODE_FON) ||
           (((mode == MODE_AUTO) || (mode == MODE_AUTO_ALT)) && busy);
  endfunction

endpackage

// File: rtl/nv_clk_gate_power_mc_if.sv
// Partition-side signal bundle of the clock gate: requests and mode in, gated clocks and status out.
// Handshake: ch_busy[i] is a level request; ch_ready[i] is the acknowledge, high only while the
// partition clock is running steadily, and the partition may issue work only while it is high.
interface nv_clk_gate_power_mc_if #(
  parameter int NUM_CH = 4,
  parameter int HYST_W = 6
);
  logic [NUM_CH-1:0]   ch_busy;
  logic [HYST_W-1:0]   hyst_cfg;
  logic [2*NUM_CH-1:0] mode_cfg;
  logic [NUM_CH-1:0]   clk_gated;
  logic [NUM_CH-1:0]   ch_ready;
  logic [NUM_CH-1:0]   ch_gated_sts;
  logic [15:0]         gate_cnt;
  logic [2*NUM_CH-1:0] dbg_state;

  modport master (
    output ch_busy, hyst_cfg, mode_cfg,
    input  clk_gated, ch_ready, ch_gated_sts, gate_cnt, dbg_state
  );

  modport slave (
    input  ch_busy, hyst_cfg, mode_cfg,
    output clk_gated, ch_ready, ch_gated_sts, gate_cnt, dbg_state
  );
endinterface

// File: rtl/nv_clk_gate_power_chan.sv
// One gated clock channel: OFF/WAKE/ON/HOLD FSM, idle hysteresis counter, enable flop
// and a low-transparent latch gate so the gated clock never carries a partial pulse.
module nv_clk_gate_power_chan
  import nv_clk_gate_pkg::*;
#(
  parameter int HYST_W = 6,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_i,
  input  logic [1:0]        mode_i,
  input  logic [HYST_W-1:0] hyst_i,
  output logic              clk_gated_o,
  output logic              ready_o,
  output logic              gated_sts_o,
  output logic              off_evt_o,
  output ch_state_e         state_o
);

  ch_state_e         state_q, state_d;
  logic [HYST_W-1:0] cnt_q, cnt_d;
  logic              req;
  logic              foff;

  assign foff = (mode_i == MODE_FOFF);
  assign req  = mode_req(mode_i, busy_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (foff) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  if (req) state_d = ST_WAKE;
        ST_WAKE: state_d = ST_ON;
        ST_ON: begin
          if (!req) begin
            if (hyst_i == '0) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = hyst_i - HYST_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (req)                state_d = ST_ON;
          else if (cnt_q == '0)   state_d = ST_OFF;
          else                    cnt_d   = cnt_q - HYST_W'(1);
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o     = state_q;
  assign gated_sts_o = (state_q == ST_OFF);

  if (BYPASS != 0) begin : g_bypass
    assign clk_gated_o = clk;
    assign ready_o     = 1'b1;
    assign off_evt_o   = 1'b0;
  end else begin : g_gate
    logic en_q;
    logic en_lat;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) en_q <= 1'b0;
      else       en_q <= (state_d != ST_OFF);
    end

    // Latch follows en_q only while clk is low, freezing it across the high phase.
    always_latch begin
      if (reset)     en_lat = 1'b0;
      else if (!clk) en_lat = en_q;
    end

    assign clk_gated_o = clk & en_lat;
    assign ready_o     = (state_q == ST_ON) || (state_q == ST_HOLD);
    assign off_evt_o   = (state_d == ST_OFF) && (state_q != ST_OFF);
  end

endmodule

// File: rtl/nv_clk_gate_power_mc.sv
// Top of the partition clock root gate: NUM_CH independent channels plus a saturating
// count of gate-off events summed across all channels each cycle.
module nv_clk_gate_power_mc
  import nv_clk_gate_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int HYST_W = 6,
  parameter int BYPASS = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  nv_clk_gate_power_mc_if.slave bus
);

  logic [NUM_CH-1:0]     clk_gated_w;
  logic [NUM_CH-1:0]     ready_w;
  logic [NUM_CH-1:0]     sts_w;
  logic [NUM_CH-1:0]     off_evt_w;
  logic [2*NUM_CH-1:0]   dbg_w;
  logic [GATE_CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [5:0]            pop;
  logic [GATE_CNT_W:0]   sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e st;

    nv_clk_gate_power_chan #(
      .HYST_W (HYST_W),
      .BYPASS (BYPASS)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .busy_i      (bus.ch_busy[i]),
      .mode_i      (bus.mode_cfg[2*i +: 2]),
      .hyst_i      (bus.hyst_cfg),
      .clk_gated_o (clk_gated_w[i]),
      .ready_o     (ready_w[i]),
      .gated_sts_o (sts_w[i]),
      .off_evt_o   (off_evt_w[i]),
      .state_o     (st)
    );

    assign dbg_w[2*i +: 2] = st;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + 6'(off_evt_w[i]);
    end
    sum        = {1'b0, gate_cnt_q} + (GATE_CNT_W + 1)'(pop);
    gate_cnt_d = sum[GATE_CNT_W] ? {GATE_CNT_W{1'b1}} : sum[GATE_CNT_W-1:0];
    if (BYPASS != 0) gate_cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gate_cnt_q <= '0;
    else       gate_cnt_q <= gate_cnt_d;
  end

  assign bus.clk_gated    = clk_gated_w;
  assign bus.ch_ready     = ready_w;
  assign bus.ch_gated_sts = sts_w;
  assign bus.gate_cnt     = gate_cnt_q;
  assign bus.dbg_state    = dbg_w;

`ifdef ASSERT_ON
  a_no_x : assert property (@(posedge clk) disable iff (reset)
    !$isunknown({bus.clk_gated, bus.ch_busy, bus.mode_cfg}));
`endif

endmodule

// File: tb/tb_nv_clk_gate_power_mc.sv
// Bench for nv_clk_gate_power_mc: directed scenarios plus random traffic, scored against
// a behavioural per-channel model through an expected queue popped by a monitor.
module tb_nv_clk_gate_power_mc;

  localparam int NUM_CH = 4;
  localparam int HYST_W = 6;
  localparam int EXP_W  = 3*NUM_CH + 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  nv_clk_gate_power_mc_if #(.NUM_CH(NUM_CH), .HYST_W(HYST_W)) bus();

  nv_clk_gate_power_mc #(
    .NUM_CH (NUM_CH),
    .HYST_W (HYST_W),
    .BYPASS (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e;
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  // Model: a channel is running or not; a fresh wake spends one cycle not ready;
  // m_idle counts remaining idle cycles (-1 = not idling).
  bit m_run[NUM_CH];
  bit m_wake[NUM_CH];
  int m_idle[NUM_CH];
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 1'b0; m_wake[i] = 1'b0; m_idle[i] = -1;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] busy, input logic [2*NUM_CH-1:0] mode,
                            input int hyst);
    logic [1:0] m;
    bit foff, req, was;
    int events;
    events = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m    = mode[2*i +: 2];
      foff = (m == 2'b10);
      req  = (m == 2'b01) || (((m == 2'b00) || (m == 2'b11)) && busy[i]);
      was  = m_run[i];
      if (foff) begin
        m_run[i] = 1'b0; m_wake[i] = 1'b0; m_idle[i] = -1;
      end else if (!m_run[i]) begin
        if (req) begin m_run[i] = 1'b1; m_wake[i] = 1'b1; end
      end else if (m_wake[i]) begin
        m_wake[i] = 1'b0;
      end else if (req) begin
        m_idle[i] = -1;
      end else if (m_idle[i] < 0) begin
        if (hyst == 0) m_run[i] = 1'b0;
        else           m_idle[i] = hyst - 1;
      end else if (m_idle[i] == 0) begin
        m_run[i] = 1'b0; m_idle[i] = -1;
      end else begin
        m_idle[i]--;
      end
      if (was && !m_run[i]) events++;
    end
    m_cnt = m_cnt + events;
    if (m_cnt > 65535) m_cnt = 65535;
  endtask

  task automatic step(input logic [NUM_CH-1:0] busy, input logic [2*NUM_CH-1:0] mode,
                      input int hyst);
    logic [NUM_CH-1:0] g, rdy, sts;
    @(negedge clk);
    bus.ch_busy  = busy;
    bus.mode_cfg = mode;
    bus.hyst_cfg = HYST_W'(hyst);
    for (int i = 0; i < NUM_CH; i++) g[i] = m_run[i];
    model_step(busy, mode, hyst);
    for (int i = 0; i < NUM_CH; i++) begin
      rdy[i] = m_run[i] && !m_wake[i];
      sts[i] = !m_run[i];
    end
    exp_q.push_back({g, rdy, sts, 16'(m_cnt)});
  endtask

  // High phase: gated clocks reflect the enable from before the edge; status reflects after.
  always @(posedge clk) begin
    #2;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("clk_gated_high", 32'(bus.clk_gated),    32'(e[16+2*NUM_CH +: NUM_CH]));
      check("ch_ready",       32'(bus.ch_ready),     32'(e[16+NUM_CH +: NUM_CH]));
      check("ch_gated_sts",   32'(bus.ch_gated_sts), 32'(e[16 +: NUM_CH]));
      check("gate_cnt",       32'(bus.gate_cnt),     32'(e[15:0]));
    end
  end

  always @(negedge clk) begin
    #2;
    if (mon_en) check("clk_gated_low", 32'(bus.clk_gated), 32'd0);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_clk_gated"}, 32'(bus.clk_gated),    32'd0);
    check({tag, "_ch_ready"},  32'(bus.ch_ready),     32'd0);
    check({tag, "_sts"},       32'(bus.ch_gated_sts), 32'hF);
    check({tag, "_gate_cnt"},  32'(bus.gate_cnt),     32'd0);
    check({tag, "_state"},     32'(bus.dbg_state),    32'd0);
  endtask

  logic [NUM_CH-1:0]   rb;
  logic [2*NUM_CH-1:0] rm;
  int                  rh;
  logic [NUM_CH-1:0]   g_pre;

  initial begin
    bus.ch_busy  = '0;
    bus.mode_cfg = '0;
    bus.hyst_cfg = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: everything stays gated.
    repeat (20) step(4'b0000, 8'h00, 3);
    // Ch0 wake and gate with hyst 3.
    repeat (10) step(4'b0001, 8'h00, 3);
    repeat (8)  step(4'b0000, 8'h00, 3);
    // Hyst 0: gate straight from ON.
    repeat (4)  step(4'b0001, 8'h00, 0);
    repeat (3)  step(4'b0000, 8'h00, 0);
    // Ch1 re-requests while its hold counter reads 1.
    repeat (4)  step(4'b0010, 8'h00, 4);
    repeat (3)  step(4'b0000, 8'h00, 4);
    repeat (4)  step(4'b0010, 8'h00, 4);
    repeat (8)  step(4'b0000, 8'h00, 4);
    // hyst_cfg change mid-hold must not disturb the running count.
    repeat (3)  step(4'b0001, 8'h00, 5);
    step(4'b0000, 8'h00, 5);
    repeat (8)  step(4'b0000, 8'h00, 1);
    // Force-off ch2 while busy, then force-on ch3 while idle.
    repeat (4)  step(4'b0100, 8'h00, 2);
    repeat (4)  step(4'b0100, 8'b0010_0000, 2);
    repeat (30) step(4'b0000, 8'b0100_0000, 2);
    // Busy toggling every cycle with hyst 1, and mode 11 acting as auto.
    for (int n = 0; n < 20; n++) step((n % 2) ? 4'b0001 : 4'b0000, 8'h00, 1);
    repeat (5)  step(4'b1010, 8'hFF, 2);
    repeat (6)  step(4'b0000, 8'hFF, 2);

    rb = '0; rm = '0; rh = 2;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 3) == 0) rb[i] = ~rb[i];
        if ($urandom_range(0, 15) == 0) begin
          case ($urandom_range(0, 5))
            0, 1, 2: rm[2*i +: 2] = 2'b00;
            3:       rm[2*i +: 2] = 2'b01;
            4:       rm[2*i +: 2] = 2'b10;
            default: rm[2*i +: 2] = 2'b11;
          endcase
        end
      end
      if ($urandom_range(0, 31) == 0) rh = $urandom_range(0, 5);
      step(rb, rm, rh);
    end

    // Asynchronous reset while all channels sit in HOLD with the clock high.
    repeat (4) step(4'b1111, 8'h00, 20);
    repeat (3) step(4'b0000, 8'h00, 20);
    @(posedge clk);
    #4;
    for (int i = 0; i < NUM_CH; i++) g_pre[i] = m_run[i];
    check("pre_reset_clk_gated", 32'(bus.clk_gated), 32'(g_pre));
    reset  = 1'b1;
    mon_en = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (3) step(4'b0000, 8'h00, 2);

    // Drive gate_cnt to 16'hFFFD, then gate all four channels on one edge.
    while (m_cnt < 16'hFFF0) begin
      step(4'b0000, 8'h55, 0);
      step(4'b0000, 8'hAA, 0);
    end
    while (m_cnt < 16'hFFFD) begin
      step(4'b0000, 8'hA9, 0);
      step(4'b0000, 8'hAA, 0);
    end
    step(4'b0000, 8'h55, 0);
    step(4'b0000, 8'hAA, 0);
    repeat (2) begin
      step(4'b0000, 8'h55, 0);
      step(4'b0000, 8'hAA, 0);
    end
    repeat (3) step(4'b0000, 8'h00, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
